// File: rtl/cdu_pkg.sv
// Shared types and defaults for the multi-channel CDU increment arbiter.
// Direction constants match the REQ_PLUS encoding seen by the AGC.
package cdu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic DIR_PLUS  = 1'b1;
    localparam logic DIR_MINUS = 1'b0;

    localparam int NCHAN_DEF   = 3;
    localparam int CW_DEF      = 15;
    localparam int BW_DEF      = 4;
    localparam int MIN_GAP_DEF = 2;

endpackage

// File: rtl/cdu_chan_backlog.sv
// One gimbal channel: signed increment backlog, mirrored angle counter and
// sticky saturation flag. Zero command overrides strobe and ack effects.
module cdu_chan_backlog
    import cdu_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int BW = BW_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_strobe,
    input  logic                 i_up,
    input  logic                 i_dn,
    input  logic                 i_zero,
    input  logic                 i_ack,
    input  logic                 i_ack_plus,
    output logic signed [BW-1:0] o_backlog,
    output logic [CW-1:0]        o_angle,
    output logic                 o_ovf
);

    localparam logic signed [BW+1:0] MAX  = (BW+2)'((1 << (BW-1)) - 1);
    localparam logic signed [BW+1:0] ONE  = {{(BW+1){1'b0}}, 1'b1};
    localparam logic signed [BW+1:0] MONE = '1;

    logic signed [BW-1:0] r_backlog;
    logic [CW-1:0]        r_angle;
    logic                 r_ovf;

    logic signed [BW+1:0] w_ext;
    logic signed [BW+1:0] w_ds;
    logic signed [BW+1:0] w_da;
    logic signed [BW+1:0] w_full;
    logic signed [BW+1:0] w_ack_only;
    logic                 w_full_ok;
    logic                 w_ack_ok;
    logic signed [BW-1:0] w_next;

    // Strobe and ack deltas are summed so a same-cycle UP and ACK(+) net out.
    always_comb begin
        w_ds = '0;
        w_da = '0;
        if (i_strobe && i_up && !i_dn) begin
            w_ds = ONE;
        end else if (i_strobe && i_dn && !i_up) begin
            w_ds = MONE;
        end
        if (i_ack) begin
            w_da = (i_ack_plus == DIR_PLUS) ? MONE : ONE;
        end
        w_ext      = {{2{r_backlog[BW-1]}}, r_backlog};
        w_full     = w_ext + w_ds + w_da;
        w_ack_only = w_ext + w_da;
        w_full_ok  = (w_full <= MAX) && (w_full >= -MAX);
        w_ack_ok   = (w_ack_only <= MAX) && (w_ack_only >= -MAX);
        if (w_full_ok) begin
            w_next = w_full[BW-1:0];
        end else if (w_ack_ok) begin
            w_next = w_ack_only[BW-1:0];
        end else begin
            w_next = r_backlog;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_zero) begin
            r_backlog <= '0;
            r_angle   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_backlog <= w_next;
            if (i_ack) begin
                r_angle <= (i_ack_plus == DIR_PLUS) ? r_angle + 1'b1 : r_angle - 1'b1;
            end
            if (!w_full_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_backlog = r_backlog;
    assign o_angle   = r_angle;
    assign o_ovf     = r_ovf;

endmodule

// File: rtl/cdu_increment_arbiter.sv
// Round-robin arbiter draining per-channel CDU backlogs to the AGC as
// PCDU/MCDU increment requests over REQ/ACK, with an enforced post-ACK gap.
module cdu_increment_arbiter
    import cdu_pkg::*;
#(
    parameter int NCHAN   = NCHAN_DEF,
    parameter int CW      = CW_DEF,
    parameter int BW      = BW_DEF,
    parameter int MIN_GAP = MIN_GAP_DEF,
    localparam int CHW    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int GW     = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1
) (
    input  logic                  CLOCKH,
    input  logic                  rst,
    input  logic                  STROBE,
    input  logic [NCHAN-1:0]      UPLVL,
    input  logic [NCHAN-1:0]      DNLVL,
    input  logic [NCHAN-1:0]      CDUZ,
    output logic                  REQ,
    output logic [CHW-1:0]        REQ_CH,
    output logic                  REQ_PLUS,
    input  logic                  ACK,
    output logic [NCHAN*CW-1:0]   ANGLE,
    output logic [NCHAN-1:0]      OVF,
    output state_t                o_dbg_state,
    output logic [NCHAN*BW-1:0]   o_dbg_backlog
);

    // Handshake: REQ_CH/REQ_PLUS are stable while REQ=1; a cycle with REQ=1 and
    // ACK=1 completes one increment. ACK with REQ=0 has no effect.

    state_t           r_state;
    state_t           w_state_nx;
    logic [CHW-1:0]   r_req_ch;
    logic [CHW-1:0]   w_req_ch_nx;
    logic             r_req_plus;
    logic             w_req_plus_nx;
    logic [CHW-1:0]   r_rr;
    logic [CHW-1:0]   w_rr_nx;
    logic [GW-1:0]    r_gap;
    logic [GW-1:0]    w_gap_nx;
    logic [NCHAN-1:0] w_ack_hit;
    logic [NCHAN-1:0] w_elig;
    logic [NCHAN-1:0] w_bl_pos;
    logic             w_any;
    logic [CHW-1:0]   w_win;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        logic signed [BW-1:0] w_backlog;

        cdu_chan_backlog #(.CW(CW), .BW(BW)) u_chan (
            .i_clk      (CLOCKH),
            .i_rst      (rst),
            .i_strobe   (STROBE),
            .i_up       (UPLVL[g]),
            .i_dn       (DNLVL[g]),
            .i_zero     (CDUZ[g]),
            .i_ack      (w_ack_hit[g]),
            .i_ack_plus (r_req_plus),
            .o_backlog  (w_backlog),
            .o_angle    (ANGLE[g*CW +: CW]),
            .o_ovf      (OVF[g])
        );

        assign w_elig[g]                 = (w_backlog != '0) && !CDUZ[g];
        assign w_bl_pos[g]               = (w_backlog != '0) && !w_backlog[BW-1];
        assign o_dbg_backlog[g*BW +: BW] = w_backlog;
    end

    // Scan from the highest offset down so the lowest offset from r_rr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int off = NCHAN - 1; off >= 0; off--) begin
            if (w_elig[(int'(r_rr) + off) % NCHAN]) begin
                w_any = 1'b1;
                w_win = CHW'((int'(r_rr) + off) % NCHAN);
            end
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_req_ch_nx   = r_req_ch;
        w_req_plus_nx = r_req_plus;
        w_rr_nx       = r_rr;
        w_gap_nx      = r_gap;
        w_ack_hit     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nx    = ST_REQ;
                    w_req_ch_nx   = w_win;
                    w_req_plus_nx = w_bl_pos[w_win];
                end
            end
            ST_REQ: begin
                if (CDUZ[r_req_ch]) begin
                    w_state_nx = ST_IDLE;
                end else if (ACK) begin
                    w_ack_hit[r_req_ch] = 1'b1;
                    w_rr_nx  = (r_req_ch == CHW'(NCHAN - 1)) ? '0 : r_req_ch + 1'b1;
                    w_gap_nx = '0;
                    w_state_nx = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap >= GW'(MIN_GAP - 1)) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_gap_nx = r_gap + 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCKH) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req_ch   <= '0;
            r_req_plus <= 1'b0;
            r_rr       <= '0;
            r_gap      <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_req_ch   <= w_req_ch_nx;
            r_req_plus <= w_req_plus_nx;
            r_rr       <= w_rr_nx;
            r_gap      <= w_gap_nx;
        end
    end

    assign REQ         = (r_state == ST_REQ);
    assign REQ_CH      = r_req_ch;
    assign REQ_PLUS    = r_req_plus;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cdu_increment_arbiter.sv
// Self-checking bench for cdu_increment_arbiter: strobe-table vectors, an
// expected-grant queue for REQ/ACK traffic, and hand-written corner sequences.
module tb_cdu_increment_arbiter;
    import cdu_pkg::*;

    localparam int NCHAN   = 3;
    localparam int CW      = 15;
    localparam int BW      = 4;
    localparam int MIN_GAP = 2;

    logic                CLOCKH = 1'b0;
    logic                rst    = 1'b0;
    logic                STROBE = 1'b0;
    logic                ACK    = 1'b0;
    logic [NCHAN-1:0]    UPLVL  = '0;
    logic [NCHAN-1:0]    DNLVL  = '0;
    logic [NCHAN-1:0]    CDUZ   = '0;
    logic                REQ;
    logic [1:0]          REQ_CH;
    logic                REQ_PLUS;
    logic [NCHAN*CW-1:0] ANGLE;
    logic [NCHAN-1:0]    OVF;
    state_t              dbg_state;
    logic [NCHAN*BW-1:0] dbg_bl;

    int n_checks = 0;
    int n_errors = 0;

    // Expected grants, {channel, plus}, in the order the DUT must issue them.
    logic [2:0] exp_q[$];

    typedef struct {
        logic [2:0]  up;
        logic [2:0]  dn;
        logic [11:0] bl;
        logic [2:0]  ovf;
    } vec_t;
    vec_t vecs[9];

    cdu_increment_arbiter #(
        .NCHAN(NCHAN), .CW(CW), .BW(BW), .MIN_GAP(MIN_GAP)
    ) dut (
        .CLOCKH        (CLOCKH),
        .rst           (rst),
        .STROBE        (STROBE),
        .UPLVL         (UPLVL),
        .DNLVL         (DNLVL),
        .CDUZ          (CDUZ),
        .REQ           (REQ),
        .REQ_CH        (REQ_CH),
        .REQ_PLUS      (REQ_PLUS),
        .ACK           (ACK),
        .ANGLE         (ANGLE),
        .OVF           (OVF),
        .o_dbg_state   (dbg_state),
        .o_dbg_backlog (dbg_bl)
    );

    always #5 CLOCKH = ~CLOCKH;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCKH);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] ang(input int ch);
        return ANGLE[ch*CW +: CW];
    endfunction

    task automatic do_reset();
        rst = 1'b1; ACK = 1'b0; CDUZ = '0; STROBE = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_strobe(input logic [2:0] up, input logic [2:0] dn);
        UPLVL = up; DNLVL = dn; STROBE = 1'b1;
        tick();
        STROBE = 1'b0; UPLVL = '0; DNLVL = '0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (REQ === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_timeout: REQ stayed 0 for 20 cycles, required 1");
        end
    endtask

    task automatic serve_one(input string nm);
        bit         ok;
        logic [2:0] e;
        wait_req(ok);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got unexpected grant 0x%0h, required none", nm, {REQ_CH, REQ_PLUS});
        end else begin
            e = exp_q.pop_front();
            if (ok) check(nm, {REQ_CH, REQ_PLUS}, e);
        end
        if (ok) begin
            ACK = 1'b1;
            tick();
            ACK = 1'b0;
        end
    endtask

    initial begin
        int highs;
        int gaps;
        bit ok;

        vecs[0] = '{up: 3'b101, dn: 3'b001, bl: 12'h100, ovf: 3'b000};
        vecs[1] = '{up: 3'b100, dn: 3'b010, bl: 12'h2F0, ovf: 3'b000};
        vecs[2] = '{up: 3'b100, dn: 3'b000, bl: 12'h3F0, ovf: 3'b000};
        vecs[3] = '{up: 3'b110, dn: 3'b000, bl: 12'h400, ovf: 3'b000};
        vecs[4] = '{up: 3'b100, dn: 3'b000, bl: 12'h500, ovf: 3'b000};
        vecs[5] = '{up: 3'b100, dn: 3'b000, bl: 12'h600, ovf: 3'b000};
        vecs[6] = '{up: 3'b100, dn: 3'b001, bl: 12'h70F, ovf: 3'b000};
        vecs[7] = '{up: 3'b100, dn: 3'b000, bl: 12'h70F, ovf: 3'b100};
        vecs[8] = '{up: 3'b000, dn: 3'b000, bl: 12'h70F, ovf: 3'b100};

        // Reset state
        do_reset();
        check("rst_req", REQ, 0);
        check("rst_req_ch", REQ_CH, 0);
        check("rst_req_plus", REQ_PLUS, 0);
        check("rst_angle", ANGLE, 0);
        check("rst_ovf", OVF, 0);
        check("rst_backlog", dbg_bl, 0);
        check("rst_state", dbg_state, ST_IDLE);

        // Three UP strobes on ch0, drained by three PLUS acks
        for (int i = 0; i < 3; i++) begin
            do_strobe(3'b001, 3'b000);
            exp_q.push_back({2'd0, 1'b1});
        end
        check("t1_backlog3", dbg_bl, 12'h003);
        for (int i = 0; i < 3; i++) serve_one("t1_grant");
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            if (REQ === 1'b1) highs++;
            tick();
        end
        check("t1_req_stays_low", highs, 0);
        check("t1_angle0", ang(0), 3);
        check("t1_backlog0", dbg_bl, 0);

        // Round-robin order 0,1,2 with the post-ack gap
        do_reset();
        do_strobe(3'b101, 3'b010);
        exp_q.push_back({2'd0, 1'b1});
        exp_q.push_back({2'd1, 1'b0});
        exp_q.push_back({2'd2, 1'b1});
        for (int g = 0; g < 2; g++) begin
            serve_one("t2_grant");
            gaps = 0;
            for (int i = 0; i < 20; i++) begin
                if (REQ === 1'b1) break;
                if (dbg_state == ST_GAP) gaps++;
                tick();
            end
            check("t2_gap_cycles", gaps, MIN_GAP);
        end
        serve_one("t2_grant");
        for (int i = 0; i < 4; i++) tick();
        check("t2_angle0", ang(0), 15'h0001);
        check("t2_angle1", ang(1), 15'h7FFF);
        check("t2_angle2", ang(2), 15'h0001);

        // Angle wrap on ch1
        do_strobe(3'b010, 3'b000);
        exp_q.push_back({2'd1, 1'b1});
        serve_one("t3_grant");
        for (int i = 0; i < 4; i++) tick();
        check("t3_angle1_wrap", ang(1), 15'h0000);
        check("t3_ovf", OVF, 0);

        // Strobe table: net deltas, both/neither, saturation on ch2
        foreach (vecs[i]) begin
            do_strobe(vecs[i].up, vecs[i].dn);
            check($sformatf("t4_vec%0d_backlog", i), dbg_bl, vecs[i].bl);
            check($sformatf("t4_vec%0d_ovf", i), OVF, vecs[i].ovf);
        end
        check("t4_req_on_ch2", {REQ, REQ_CH}, {1'b1, 2'd2});
        CDUZ = 3'b100;
        tick();
        CDUZ = '0;
        check("t4_zero_backlog", dbg_bl, 12'h00F);
        check("t4_zero_angle2", ang(2), 0);
        check("t4_zero_ovf", OVF, 0);
        check("t4_zero_req_drop", REQ, 0);
        check("t4_zero_state", dbg_state, ST_IDLE);
        tick();
        check("t4_no_gap_req", REQ, 1);
        exp_q.push_back({2'd0, 1'b0});
        serve_one("t4_grant_ch0_minus");
        for (int i = 0; i < 4; i++) tick();
        check("t4_angle0", ang(0), 0);
        check("t4_backlog_all0", dbg_bl, 0);

        // CDUZ with ACK on the pending channel, then ch1 follows without a gap
        do_reset();
        do_strobe(3'b001, 3'b000);
        do_strobe(3'b001, 3'b000);
        exp_q.push_back({2'd0, 1'b1});
        serve_one("t5_grant0");
        wait_req(ok);
        check("t5_req_ch0", {REQ, REQ_CH}, {1'b1, 2'd0});
        do_strobe(3'b010, 3'b000);
        CDUZ = 3'b001;
        ACK  = 1'b1;
        tick();
        CDUZ = '0;
        ACK  = 1'b0;
        check("t5_req_drop", REQ, 0);
        check("t5_state_idle", dbg_state, ST_IDLE);
        check("t5_angle0", ang(0), 0);
        check("t5_backlog", dbg_bl, 12'h010);
        tick();
        check("t5_no_gap_req", REQ, 1);
        exp_q.push_back({2'd1, 1'b1});
        serve_one("t5_grant1");
        check("t5_angle1", ang(1), 1);

        // Same-cycle UP and ACK(+) on ch0, then reset during a request
        do_reset();
        do_strobe(3'b001, 3'b000);
        wait_req(ok);
        UPLVL = 3'b001; STROBE = 1'b1; ACK = 1'b1;
        tick();
        UPLVL = '0; STROBE = 1'b0; ACK = 1'b0;
        check("t6_net_backlog", dbg_bl, 12'h001);
        check("t6_net_angle0", ang(0), 1);
        wait_req(ok);
        check("t6_pre_plus", REQ_PLUS, 1);
        rst = 1'b1;
        ACK = 1'b1;
        tick();
        rst = 1'b0;
        ACK = 1'b0;
        check("t6_rst_req", REQ, 0);
        check("t6_rst_plus", REQ_PLUS, 0);
        check("t6_rst_ch", REQ_CH, 0);
        check("t6_rst_angle", ANGLE, 0);
        check("t6_rst_ovf", OVF, 0);
        check("t6_rst_backlog", dbg_bl, 0);
        check("t6_rst_state", dbg_state, ST_IDLE);

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
